// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings the fabric PLL from power-up to a usable core clock. It pulses the PLL
// reset and waits for lock. A timed-out attempt is retried until the retry budget
// runs out. Lock must stay stable through a filter window and a release delay
// before core_rst_n is let go. All logic runs on the free-running refclk.
//
// Build option: define PLL_AUTORECOVER_EN to make lock loss in RUN trigger a full
// automatic re-sequence with a fresh retry budget. Without it, lock loss in RUN
// parks the block in FAULT until rst_n or soft_reset.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned RELEASE_DELAY  = 256,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       core_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    // The shared counter is sized for the longest interval it ever has to time.
    localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
    localparam int unsigned MAX_CD = (LOCK_TIMEOUT > RELEASE_DELAY) ? LOCK_TIMEOUT : RELEASE_DELAY;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW     = (MAX_P < 2) ? 2 : $clog2(MAX_P + 1);

    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_DELAY - 1);

    if ((PLL_RST_CYCLES < 2) || (LOCK_FILTER == 0) || (LOCK_TIMEOUT == 0) ||
        (RELEASE_DELAY == 0) || (MAX_RETRIES == 0)) begin : g_param_check
        $error("pll_reset_sequencer: PLL_RST_CYCLES must be >= 2 and all other parameters non-zero");
    end

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [3:0]    retry_s;
    logic [3:0]    retry_inc_s;
    logic          retry_left_s;
    logic          lock_meta_r;
    logic          lock_sync_r;

    assign retry_left_s = (32'(retry_count) < MAX_RETRIES);
    assign retry_inc_s  = (retry_count == 4'd15) ? 4'd15 : (retry_count + 4'd1);

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Next state, shared counter and retry bookkeeping; soft_reset overrides all.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_ONE;
        retry_s = retry_count;
        if (soft_reset) begin
            state_s = ST_RESET_PLL;
            cnt_s   = CNT_ZERO;
            retry_s = 4'd0;
        end else begin
            case (state_r)
                ST_RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_RESET_PLL;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync_r) begin
                        state_s = ST_FILTER;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (retry_left_s) begin
                            state_s = ST_RESET_PLL;
                            retry_s = retry_inc_s;
                        end else begin
                            state_s = ST_FAULT;
                        end
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_FILTER: begin
                    if (!lock_sync_r) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == FILTER_LAST) begin
                        state_s = ST_RELEASE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_FILTER;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_sync_r) begin
                        // Losing lock here counts as a failed attempt.
                        cnt_s = CNT_ZERO;
                        if (retry_left_s) begin
                            state_s = ST_RESET_PLL;
                            retry_s = retry_inc_s;
                        end else begin
                            state_s = ST_FAULT;
                        end
                    end else if (cnt_r == RELEASE_LAST) begin
                        state_s = ST_RUN;
                        cnt_s   = CNT_ZERO;
                        retry_s = 4'd0;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    cnt_s = CNT_ZERO;
                    if (!lock_sync_r) begin
`ifdef PLL_AUTORECOVER_EN
                        state_s = ST_RESET_PLL;
                        retry_s = 4'd0;
`else
                        state_s = ST_FAULT;
`endif
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                    cnt_s   = CNT_ZERO;
                end
                default: begin
                    state_s = ST_RESET_PLL;
                    cnt_s   = CNT_ZERO;
                    retry_s = 4'd0;
                end
            endcase
        end
    end

    // State, counter and registered outputs decoded from the upcoming state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RESET_PLL;
            cnt_r       <= CNT_ZERO;
            retry_count <= 4'd0;
            pll_rst     <= 1'b1;
            core_rst_n  <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            retry_count <= retry_s;
            pll_rst     <= (state_s == ST_RESET_PLL) || (state_s == ST_FAULT);
            core_rst_n  <= (state_s == ST_RUN);
            ready       <= (state_s == ST_RUN);
            fault       <= (state_s == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Directed scenarios with randomised lock timing. Expected cycle counts are
// computed from the sequencing rules (sync latency + filter + release delay,
// reset pulse width, timeout spacing). Build with PLL_AUTORECOVER_EN defined to
// exercise the auto-recovery variant.
module tb_pll_reset_sequencer;

    localparam int P_RST   = 4;
    localparam int P_FILT  = 8;
    localparam int P_TO    = 32;
    localparam int P_REL   = 4;
    localparam int P_RETRY = 2;
    // Negedges from driving pll_locked high (just after a negedge) to seeing
    // core_rst_n high: 1 to reach the sampling edge, then 2 + filter + release.
    localparam int NOMINAL   = 1 + 2 + P_FILT + P_REL;
    // Negedges from first seeing pll_rst low to core_rst_n high when lock is
    // already synchronised: one edge into the filter, then filter + release.
    localparam int PRELOCKED = 1 + P_FILT + P_REL;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       core_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int tests;
    int failed;
    int n;
    int d;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_FILTER   (P_FILT),
        .LOCK_TIMEOUT  (P_TO),
        .RELEASE_DELAY (P_REL),
        .MAX_RETRIES   (P_RETRY)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .soft_reset (soft_reset),
        .pll_rst    (pll_rst),
        .core_rst_n (core_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_bit({tag, "_pll_rst"}, pll_rst, 1'b1);
        chk_bit({tag, "_core_rst_n"}, core_rst_n, 1'b0);
        chk_bit({tag, "_ready"}, ready, 1'b0);
        chk_bit({tag, "_fault"}, fault, 1'b0);
        chk_int({tag, "_retry"}, int'(retry_count), 0);
    endtask

    // Length of the current pll_rst run (current negedge counts as one);
    // returns on the first negedge showing the opposite level.
    task automatic run_len(input logic lvl, output int len);
        len = 1;
        while (len < 200) begin
            @(negedge refclk);
            if (pll_rst !== lvl) break;
            len++;
        end
    endtask

    // Negedges until core_rst_n shows lvl, bounded.
    task automatic wait_core(input logic lvl, output int len);
        len = 0;
        do begin
            @(negedge refclk);
            len++;
        end while ((core_rst_n !== lvl) && (len < 200));
    endtask

    task automatic pulse_soft();
        soft_reset = 1'b1;
        @(negedge refclk);
        soft_reset = 1'b0;
    endtask

    // Continuous output invariants.
    always @(negedge refclk) begin
        if (rst_n === 1'b1) begin
            tests++;
            assert (ready === core_rst_n) else begin
                failed++;
                $error("FAIL inv_ready: observed %b, expected %b", ready, core_rst_n);
            end
            if (core_rst_n === 1'b1) begin
                tests++;
                assert (pll_rst === 1'b0) else begin
                    failed++;
                    $error("FAIL inv_core_vs_pll_rst: observed pll_rst %b, expected 0", pll_rst);
                end
            end
        end
    end

    initial begin
        tests      = 0;
        failed     = 0;
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        soft_reset = 1'b0;

        // Asynchronous power-on reset, checked before any clock edge.
        #3 rst_n = 1'b0;
        #2;
        chk_idle("por");
        repeat (3) @(negedge refclk);
        #5 rst_n = 1'b1;

        // Power-up, clean lock 10 cycles after pll_rst falls.
        run_len(1'b1, n);
        chk_int("pwr_pll_rst_width", n, P_RST);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        wait_core(1'b1, n);
        chk_int("pwr_release_latency", n, NOMINAL);
        chk_bit("pwr_ready", ready, 1'b1);
        chk_bit("pwr_pll_rst", pll_rst, 1'b0);
        chk_int("pwr_retry", int'(retry_count), 0);
        repeat (3) @(negedge refclk);
        chk_bit("run_ready_held", ready, 1'b1);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        wait_core(1'b0, n);
        chk_int("loss_latency", n, 3);
        chk_bit("loss_ready", ready, 1'b0);
        chk_bit("loss_pll_rst", pll_rst, 1'b1);
        chk_int("loss_retry", int'(retry_count), 0);
`ifdef PLL_AUTORECOVER_EN
        chk_bit("loss_fault", fault, 1'b0);
        run_len(1'b1, n);
        chk_int("auto_pll_rst_width", n, P_RST);
        d = int'($urandom_range(20, 1));
        repeat (d) @(negedge refclk);
        pll_locked = 1'b1;
        wait_core(1'b1, n);
        chk_int("auto_release_latency", n, NOMINAL);
        chk_bit("auto_fault", fault, 1'b0);
`else
        chk_bit("loss_fault", fault, 1'b1);
        repeat (5) @(negedge refclk);
        chk_bit("loss_fault_sticky", fault, 1'b1);
        chk_bit("loss_core_low", core_rst_n, 1'b0);
`endif

        // soft_reset, then PLL never locks: three pulses, two retries, FAULT.
        pll_locked = 1'b0;
        pulse_soft();
        chk_idle("soft1");
        run_len(1'b1, n);
        chk_int("never_pulse0", n, P_RST);
        for (int i = 1; i <= P_RETRY + 1; i++) begin
            run_len(1'b0, n);
            chk_int("never_timeout_gap", n, P_TO);
            if (i <= P_RETRY) begin
                chk_int("never_retry", int'(retry_count), i);
                chk_bit("never_fault_early", fault, 1'b0);
                run_len(1'b1, n);
                chk_int("never_pulse", n, P_RST);
            end
        end
        chk_bit("never_fault", fault, 1'b1);
        chk_bit("never_pll_rst", pll_rst, 1'b1);
        chk_int("never_retry_final", int'(retry_count), P_RETRY);
        repeat (6) @(negedge refclk);
        chk_bit("never_fault_sticky", fault, 1'b1);
        chk_bit("never_pll_rst_sticky", pll_rst, 1'b1);
        chk_bit("never_core_low", core_rst_n, 1'b0);

        // soft_reset out of FAULT, then a one-cycle lock glitch during FILTER.
        pulse_soft();
        chk_idle("soft_fault");
        run_len(1'b1, n);
        chk_int("glitch_pll_rst_width", n, P_RST);
        d = int'($urandom_range(15, 1));
        repeat (d) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_core(1'b1, n);
        chk_int("glitch_release_latency", n, NOMINAL);
        chk_int("glitch_retry", int'(retry_count), 0);

        // soft_reset in the middle of RELEASE (lock stays high throughout).
        pulse_soft();
        chk_idle("soft_run");
        run_len(1'b1, n);
        chk_int("rel_pll_rst_width", n, P_RST);
        repeat (1 + P_FILT + 1) @(negedge refclk);
        chk_bit("rel_core_still_low", core_rst_n, 1'b0);
        pulse_soft();
        chk_idle("soft_release");
        run_len(1'b1, n);
        chk_int("rel_resume_pll_rst_width", n, P_RST);
        wait_core(1'b1, n);
        chk_int("rel_resume_latency", n, PRELOCKED);

        // Async reset in WAIT_LOCK after one retry has been used.
        pll_locked = 1'b0;
        pulse_soft();
        run_len(1'b1, n);
        chk_int("arst_pll_rst_width", n, P_RST);
        run_len(1'b0, n);
        chk_int("arst_timeout_gap", n, P_TO);
        chk_int("arst_retry_before", int'(retry_count), 1);
        run_len(1'b1, n);
        d = int'($urandom_range(20, 2));
        repeat (d) @(negedge refclk);
        #5 rst_n = 1'b0;
        #2;
        chk_idle("arst");
        pll_locked = 1'b1;
        #1 rst_n = 1'b1;
        run_len(1'b1, n);
        chk_int("arst_restart_pll_rst_width", n, P_RST);
        wait_core(1'b1, n);
        chk_int("arst_release_latency", n, PRELOCKED);
        chk_int("arst_retry_after", int'(retry_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
